// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM32 duty sequencer: state encoding and table size limits.
package pwm_seq_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
  localparam logic [1:0] ST_RUN_ENC      = 2'd1;
  localparam logic [1:0] ST_STOPPING_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_RUN      = ST_RUN_ENC,
    ST_STOPPING = ST_STOPPING_ENC
  } seq_state_e;

endpackage

// File: rtl/pwm_seq_table.sv
// Duty table: DEPTH x 32 register file, one synchronous write port,
// one combinational read port, cleared by the asynchronous reset.
module pwm_seq_table #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  // Next table contents: only in-range addresses take a write.
  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem_d[waddr] = wdata;
    end
  end

  // Read returns the stored value; an unpopulated address reads as zero.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < 32'(DEPTH)) begin
      rdata = mem_q[raddr];
    end
  end

  // Table storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM32 duty sequencer: steps TMRCMP2 through the duty table once per PWM
// period, for a programmed number of passes or until stopped.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | PWM disabled, waiting for start with a non-zero length
//   ST_RUN      | stepping the table on every period_tick
//   ST_STOPPING | stop seen; finishing the current period, then end
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic [31:0]   pre_in,
  input  logic [31:0]   period_in,
  input  logic [AW:0]   seq_len,
  input  logic [RW-1:0] rep_in,
  input  logic          start,
  input  logic          stop,
  input  logic          period_tick,
  output logic [31:0]   PRE,
  output logic [31:0]   TMRCMP1,
  output logic [31:0]   TMRCMP2,
  output logic          TMREN,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step_idx
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("pwm_seq_ctrl: DEPTH out of supported range");
  end

  seq_state_e    state_q, state_d;
  logic [31:0]   pre_q, pre_d;
  logic [31:0]   per_q, per_d;
  logic [31:0]   cmp2_q, cmp2_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [RW-1:0] rep_q, rep_d;

  logic [AW-1:0] nxt_idx;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          last_step;
  logic          end_seq;

  pwm_seq_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next table index with wrap at the end of a pass; IDLE always preloads entry 0.
  always_comb begin
    last_step = ({1'b0, idx_q} == (len_q - 1'b1));
    nxt_idx   = last_step ? '0 : idx_q + 1'b1;
    rd_addr   = (state_q == ST_IDLE) ? '0 : nxt_idx;
  end

  // Sequencer next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    per_d   = per_q;
    cmp2_d  = cmp2_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    len_d   = len_q;
    rep_d   = rep_q;
    end_seq = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (seq_len != '0)) begin
          state_d = ST_RUN;
          pre_d   = pre_in;
          per_d   = period_in;
          len_d   = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
          rep_d   = rep_in;
          idx_d   = '0;
          cmp2_d  = rd_data;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (period_tick) begin
          // rep_q == 0 means run forever, so it is never decremented.
          if (last_step && (rep_q != '0)) begin
            rep_d = rep_q - 1'b1;
          end
          if (stop || (last_step && (rep_q == RW'(1)))) begin
            end_seq = 1'b1;
          end else begin
            idx_d  = nxt_idx;
            cmp2_d = rd_data;
          end
        end else if (stop) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (period_tick) begin
          end_seq = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ending holds PRE/TMRCMP1/TMRCMP2/step_idx at their last values.
    if (end_seq) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // State and output registers; reset drops the PWM drive immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      per_q   <= '0;
      cmp2_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      per_q   <= per_d;
      cmp2_q  <= cmp2_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
    end
  end

  assign PRE      = pre_q;
  assign TMRCMP1  = per_q;
  assign TMRCMP2  = cmp2_q;
  assign TMREN    = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule
